car_action_arbiter: RTL and testbench



---
 rtl/car_action_arbiter.sv | 165 ++++++++++++++++
 tb/tb_car_action_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_action_arbiter.sv
// Motion-command arbiter: picks one action per car mode and applies
// dwell, brake-on-reversal/mode-change, obstacle lock and IR watchdog.
module car_action_arbiter #(
  parameter int HOLD_CYCLES  = 3000,
  parameter int BRAKE_CYCLES = 2000,
  parameter int IR_TIMEOUT   = 10000,
  parameter int SAFE_DIST    = 20,
  parameter int HYST_DIST    = 5
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [3:0]  act_ir,
  input  logic        ir_valid,
  input  logic [3:0]  act_track,
  input  logic [3:0]  act_avoid,
  input  logic [15:0] dist_cm,
  input  logic        dist_valid,
  output logic [3:0]  action,
  output logic [1:0]  state,
  output logic        obstacle_lock,
  output logic        ir_timed_out
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
  localparam int IW = (IR_TIMEOUT > 1) ? $clog2(IR_TIMEOUT) : 1;

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BRAKE_LAST = BW'(BRAKE_CYCLES - 1);
  localparam logic [IW-1:0] IR_LAST    = IW'(IR_TIMEOUT - 1);
  localparam logic [IW-1:0] IR_PRE     = IW'(IR_TIMEOUT - 2);
  localparam logic [15:0]   SET_CM     = 16'(SAFE_DIST);
  localparam logic [15:0]   CLR_CM     = 16'(SAFE_DIST + HYST_DIST);

  localparam logic [3:0] A_STOP  = 4'd0;
  localparam logic [3:0] A_FWD   = 4'd1;
  localparam logic [3:0] A_BWD   = 4'd2;
  localparam logic [3:0] A_LEFT  = 4'd3;
  localparam logic [3:0] A_RIGHT = 4'd4;

  typedef enum logic [1:0] {
    S_STOP  = 2'b00,
    S_RUN   = 2'b01,
    S_BRAKE = 2'b10
  } st_t;

  st_t           st;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] brake_cnt;
  logic [IW-1:0] ir_cnt;
  logic [1:0]    prev_mode;
  logic [3:0]    src;
  logic [3:0]    cand;
  logic          rev;

  function automatic logic [3:0] legal(input logic [3:0] a);
    return (a <= A_RIGHT) ? a : A_STOP;
  endfunction

  always_comb begin
    src = A_STOP;
    case (mode)
      2'b00:   src = ir_timed_out ? A_STOP : legal(act_ir);
      2'b01:   src = legal(act_track);
      2'b10:   src = legal(act_avoid);
      default: src = A_STOP;
    endcase
    cand = src;
    // avoidance mode is allowed to creep forward past the lock
    if (!mode[1] && obstacle_lock && src == A_FWD)
      cand = A_STOP;
  end

  assign rev = (action == A_FWD   && cand == A_BWD)   ||
               (action == A_BWD   && cand == A_FWD)   ||
               (action == A_LEFT  && cand == A_RIGHT) ||
               (action == A_RIGHT && cand == A_LEFT);

  assign state = st;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      ir_cnt       <= '0;
      ir_timed_out <= 1'b1;
    end else if (ir_valid) begin
      ir_cnt       <= '0;
      ir_timed_out <= 1'b0;
    end else begin
      if (ir_cnt != IR_LAST)
        ir_cnt <= ir_cnt + 1'b1;
      if (ir_cnt >= IR_PRE)
        ir_timed_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst)
      obstacle_lock <= 1'b0;
    else if (dist_valid && dist_cm != 16'd0) begin
      if (dist_cm < SET_CM)
        obstacle_lock <= 1'b1;
      else if (dist_cm >= CLR_CM)
        obstacle_lock <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      st        <= S_STOP;
      action    <= A_STOP;
      hold_cnt  <= '0;
      brake_cnt <= '0;
      prev_mode <= mode;
    end else begin
      prev_mode <= mode;
      case (st)
        S_STOP: begin
          if (cand != A_STOP) begin
            st       <= S_RUN;
            action   <= cand;
            hold_cnt <= '0;
          end
        end
        S_RUN: begin
          if (cand == A_STOP) begin
            st     <= S_STOP;
            action <= A_STOP;
          end else if (mode != prev_mode) begin
            st        <= S_BRAKE;
            action    <= A_STOP;
            brake_cnt <= '0;
          end else if (cand != action && hold_cnt >= HOLD_LAST) begin
            if (rev) begin
              st        <= S_BRAKE;
              action    <= A_STOP;
              brake_cnt <= '0;
            end else begin
              action   <= cand;
              hold_cnt <= '0;
            end
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_BRAKE: begin
          if (cand == A_STOP) begin
            st <= S_STOP;
          end else if (brake_cnt == BRAKE_LAST) begin
            st       <= S_RUN;
            action   <= cand;
            hold_cnt <= '0;
          end else begin
            brake_cnt <= brake_cnt + 1'b1;
          end
        end
        default: begin
          st     <= S_STOP;
          action <= A_STOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_action_arbiter.sv
// Bench for car_action_arbiter: directed plan checks with literal
// expectations, then random traffic against a behavioural model.
module tb_car_action_arbiter;

  localparam int HOLD = 3;
  localparam int BRK  = 4;
  localparam int IRT  = 20;
  localparam int SAFE = 20;
  localparam int HYST = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd1;
  logic [3:0]  act_ir = 4'd0;
  logic        ir_valid = 1'b0;
  logic [3:0]  act_track = 4'd1;
  logic [3:0]  act_avoid = 4'd0;
  logic [15:0] dist_cm = 16'd0;
  logic        dist_valid = 1'b0;
  logic [3:0]  action;
  logic [1:0]  state;
  logic        obstacle_lock;
  logic        ir_timed_out;

  int total = 0;
  int bad = 0;

  car_action_arbiter #(
    .HOLD_CYCLES (HOLD),
    .BRAKE_CYCLES(BRK),
    .IR_TIMEOUT  (IRT),
    .SAFE_DIST   (SAFE),
    .HYST_DIST   (HYST)
  ) dut (
    .clk_in       (clk),
    .rst          (rst),
    .mode         (mode),
    .act_ir       (act_ir),
    .ir_valid     (ir_valid),
    .act_track    (act_track),
    .act_avoid    (act_avoid),
    .dist_cm      (dist_cm),
    .dist_valid   (dist_valid),
    .action       (action),
    .state        (state),
    .obstacle_lock(obstacle_lock),
    .ir_timed_out (ir_timed_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: ages and countdowns instead of saturating counters
  int m_act, m_st, m_age, m_brk_left, m_prev, m_since, m_cand;
  bit m_lock;
  bit m_on = 1'b0;

  function automatic int norm(input logic [3:0] a);
    return (a <= 4) ? int'(a) : 0;
  endfunction

  function automatic bit opposite(input int a, input int c);
    return (a == 1 && c == 2) || (a == 2 && c == 1) ||
           (a == 3 && c == 4) || (a == 4 && c == 3);
  endfunction

  function automatic bit m_to();
    return (m_since < 0) || (m_since >= IRT - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_st = 0; m_age = 0; m_brk_left = 0;
      m_prev = mode; m_since = -1; m_lock = 0; m_on = 1;
    end else begin
      case (mode)
        2'd0: m_cand = m_to() ? 0 : norm(act_ir);
        2'd1: m_cand = norm(act_track);
        2'd2: m_cand = norm(act_avoid);
        default: m_cand = 0;
      endcase
      if (mode < 2 && m_lock && m_cand == 1) m_cand = 0;
      if (m_st == 0) begin
        if (m_cand != 0) begin m_st = 1; m_act = m_cand; m_age = 0; end
      end else if (m_st == 1) begin
        if (m_cand == 0) begin
          m_st = 0; m_act = 0;
        end else if (mode != m_prev ||
                     (m_cand != m_act && m_age >= HOLD - 1 &&
                      opposite(m_act, m_cand))) begin
          m_st = 2; m_act = 0; m_brk_left = BRK - 1;
        end else if (m_cand != m_act && m_age >= HOLD - 1) begin
          m_act = m_cand; m_age = 0;
        end else begin
          m_age++;
        end
      end else begin
        if (m_cand == 0) m_st = 0;
        else if (m_brk_left == 0) begin m_st = 1; m_act = m_cand; m_age = 0; end
        else m_brk_left--;
      end
      if (dist_valid && dist_cm != 0) begin
        if (dist_cm < SAFE) m_lock = 1;
        else if (dist_cm >= SAFE + HYST) m_lock = 0;
      end
      if (ir_valid) m_since = 0;
      else if (m_since >= 0 && m_since < 1000) m_since++;
      m_prev = mode;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_action", action, m_act);
      chk("model_state", state, m_st);
      chk("model_lock", obstacle_lock, m_lock);
      chk("model_ir_to", ir_timed_out, m_to());
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1: reset and dwell
    step(1);
    chk("rst_action", action, 0);
    chk("rst_state", state, 0);
    chk("rst_lock", obstacle_lock, 0);
    chk("rst_ir_to", ir_timed_out, 1);
    rst = 0;
    step(1);
    chk("t1_first_act", action, 1);
    chk("t1_first_state", state, 1);
    step(1);
    act_track = 4'd3;
    step(1);
    chk("t1_dwell_hold", action, 1);
    step(1);
    chk("t1_dwell_change", action, 3);
    // 2: reversal brake, then stop mid-brake
    act_track = 4'd4;
    step(2);
    chk("t2_pre_rev", action, 3);
    for (int i = 0; i < BRK; i++) begin
      step(1);
      chk("t2_brake_state", state, 2);
      chk("t2_brake_act", action, 0);
    end
    step(1);
    chk("t2_after_brake_act", action, 4);
    chk("t2_after_brake_state", state, 1);
    act_track = 4'd3;
    step(3);
    chk("t2_brake2_state", state, 2);
    step(1);
    act_track = 4'd0;
    step(1);
    chk("t2_mid_stop_state", state, 0);
    chk("t2_mid_stop_act", action, 0);
    // 3: obstacle lock with hysteresis
    act_track = 4'd1;
    step(1);
    chk("t3_fwd", action, 1);
    dist_cm = 16'd15; dist_valid = 1;
    step(1);
    dist_valid = 0;
    chk("t3_lock_set", obstacle_lock, 1);
    step(1);
    chk("t3_locked_act", action, 0);
    dist_cm = 16'd22; dist_valid = 1;
    step(1);
    dist_valid = 0;
    chk("t3_lock_hold", obstacle_lock, 1);
    step(1);
    chk("t3_hold_act", action, 0);
    dist_cm = 16'd25; dist_valid = 1;
    step(1);
    dist_valid = 0;
    chk("t3_lock_clr", obstacle_lock, 0);
    step(1);
    chk("t3_resume", action, 1);
    dist_cm = 16'd0; dist_valid = 1;
    step(1);
    dist_valid = 0;
    chk("t3_zero_lock", obstacle_lock, 0);
    chk("t3_zero_act", action, 1);
    // 4: IR watchdog
    mode = 2'd3;
    step(1);
    chk("t4_forced_stop", state, 0);
    mode = 2'd0; act_ir = 4'd1; ir_valid = 1;
    step(1);
    ir_valid = 0;
    chk("t4_ir_to_clr", ir_timed_out, 0);
    step(1);
    chk("t4_ir_fwd", action, 1);
    step(17);
    chk("t4_pre_to", ir_timed_out, 0);
    chk("t4_pre_to_act", action, 1);
    step(1);
    chk("t4_to_set", ir_timed_out, 1);
    step(1);
    chk("t4_to_act", action, 0);
    ir_valid = 1;
    step(1);
    ir_valid = 0;
    chk("t4_to_clr2", ir_timed_out, 0);
    step(1);
    chk("t4_resume", action, 1);
    step(17);
    chk("t4_before_term", ir_timed_out, 0);
    ir_valid = 1;
    step(1);
    ir_valid = 0;
    chk("t4_term_valid", ir_timed_out, 0);
    step(1);
    chk("t4_term_after", ir_timed_out, 0);
    chk("t4_term_act", action, 1);
    // 5: mode change brake, lock exempt in avoid mode
    mode = 2'd1; act_track = 4'd1;
    step(BRK);
    chk("t5_mc_brake", state, 2);
    step(1);
    chk("t5_trk_fwd", action, 1);
    mode = 2'd2; act_avoid = 4'd1;
    step(1);
    chk("t5_brake_in", state, 2);
    step(BRK);
    chk("t5_avoid_act", action, 1);
    chk("t5_avoid_state", state, 1);
    dist_cm = 16'd10; dist_valid = 1;
    step(1);
    dist_valid = 0;
    chk("t5_lock", obstacle_lock, 1);
    step(1);
    chk("t5_exempt", action, 1);
    // 6: reset in the middle of a brake
    mode = 2'd1; act_track = 4'd3;
    step(1);
    chk("t6_brake", state, 2);
    step(1);
    rst = 1;
    step(1);
    chk("t6_rst_state", state, 0);
    chk("t6_rst_act", action, 0);
    chk("t6_rst_ir_to", ir_timed_out, 1);
    chk("t6_rst_lock", obstacle_lock, 0);
    rst = 0;
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) act_ir = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) act_track = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) act_avoid = 4'($urandom_range(0, 7));
      ir_valid = ($urandom_range(0, 11) == 0);
      dist_valid = ($urandom_range(0, 3) == 0);
      dist_cm = 16'($urandom_range(0, 40));
      step(1);
    end
    rst = 0; ir_valid = 0; dist_valid = 0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
